// File: rtl/ro_freq_counter.sv
// Ring-oscillator edge counter: enables the RO, synchronises its output and counts rising edges over a fixed clk window.
// Optional build macro RO_CNT_SETTLE_EN adds an RO warm-up phase (SETTLE_CYCLES) before counting starts.
module ro_freq_counter #(
  parameter int unsigned WINDOW_CYCLES = 4096,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned CTR_MAX = (WINDOW_CYCLES > SYNC_STAGES) ? WINDOW_CYCLES : SYNC_STAGES;
  localparam int unsigned CTR_W   = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;
`ifdef RO_CNT_SETTLE_EN
  localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`endif

  // Elaboration-time parameter legality
  if (WINDOW_CYCLES < 1) begin : g_chk_win
    $error("WINDOW_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle
    $error("SETTLE_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
`ifdef RO_CNT_SETTLE_EN
    S_SETTLE = 3'd4,
`endif
    S_COUNT  = 3'd1,
    S_DRAIN  = 3'd2,
    S_DONE   = 3'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CTR_W-1:0]       win_ctr_q, win_ctr_d;
`ifdef RO_CNT_SETTLE_EN
  logic [SET_W-1:0]       set_ctr_q, set_ctr_d;
`endif
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic [SYNC_STAGES-1:0] win_dly_q, win_dly_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   ro_enable_q, ro_enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept_c;
  logic                   rise_c;

  // Synchroniser, edge detector and window flag delayed to match sample age
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], ro_in};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    win_dly_d   = {win_dly_q[SYNC_STAGES-2:0], (state_q == S_COUNT)};
    rise_c      = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    win_ctr_d = win_ctr_q;
`ifdef RO_CNT_SETTLE_EN
    set_ctr_d = set_ctr_q;
`endif
    accept_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          win_ctr_d = CTR_W'(WINDOW_CYCLES - 1);
`ifdef RO_CNT_SETTLE_EN
          set_ctr_d = SET_W'(SETTLE_CYCLES - 1);
          state_d   = S_SETTLE;
`else
          state_d   = S_COUNT;
`endif
        end
      end
`ifdef RO_CNT_SETTLE_EN
      S_SETTLE: begin
        if (set_ctr_q == '0) begin
          state_d = S_COUNT;
        end else begin
          set_ctr_d = set_ctr_q - SET_W'(1);
        end
      end
`endif
      S_COUNT: begin
        if (win_ctr_q == '0) begin
          state_d   = S_DRAIN;
          win_ctr_d = CTR_W'(SYNC_STAGES - 1);
        end else begin
          win_ctr_d = win_ctr_q - CTR_W'(1);
        end
      end
      S_DRAIN: begin
        if (win_ctr_q == '0) begin
          state_d = S_DONE;
        end else begin
          win_ctr_d = win_ctr_q - CTR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating edge counter and registered outputs derived from the next state
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept_c) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (win_dly_q[SYNC_STAGES-1] && rise_c) begin
      if (&count_q) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
`ifdef RO_CNT_SETTLE_EN
    ro_enable_d = (state_d == S_COUNT) || (state_d == S_SETTLE);
`else
    ro_enable_d = (state_d == S_COUNT);
`endif
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      win_ctr_q   <= '0;
`ifdef RO_CNT_SETTLE_EN
      set_ctr_q   <= '0;
`endif
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      win_dly_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      ro_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_ctr_q   <= win_ctr_d;
`ifdef RO_CNT_SETTLE_EN
      set_ctr_q   <= set_ctr_d;
`endif
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      win_dly_q   <= win_dly_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      ro_enable_q <= ro_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ro_enable = ro_enable_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: 64-cycle window, plus a 3-bit-count instance for saturation.
module tb_ro_freq_counter;

`ifdef RO_CNT_SETTLE_EN
  localparam int D = 16;
`else
  localparam int D = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ro_in = 1'b0;
  logic        ro_enable, busy, done, overflow;
  logic [15:0] count;
  logic        s_ro_enable, s_busy, s_done, s_overflow;
  logic [2:0]  s_count;

  int errors = 0;
  int checks = 0;

  ro_freq_counter #(.WINDOW_CYCLES(64), .CNT_W(16), .SYNC_STAGES(2), .SETTLE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in),
    .ro_enable(ro_enable), .busy(busy), .done(done), .count(count), .overflow(overflow));

  ro_freq_counter #(.WINDOW_CYCLES(64), .CNT_W(3), .SYNC_STAGES(2), .SETTLE_CYCLES(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in),
    .ro_enable(s_ro_enable), .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_overflow));

  always #5 clk = ~clk;

  // RO model: 0 = clk/4 wave gated by ro_enable, 1 = held 0, 2 = held 1, 3 = free toggle
  int       mode = 0;
  int       ph = 0;
  always @(negedge clk) begin
    case (mode)
      0: begin
        if (ro_enable) begin
          ph = (ph + 1) % 4;
          ro_in = (ph >= 2);
        end else begin
          ph = 0;
          ro_in = 1'b0;
        end
      end
      1: ro_in = 1'b0;
      2: ro_in = 1'b1;
      default: ro_in = ~ro_in;
    endcase
  end

  int          starts[$];
  int          n_done, done_cyc, done_cyc2, en_first, en_last;
  logic [15:0] cnt_done;
  logic        ovf_done, busy_done, busy_c1, sovf_done, sdone_seen;
  logic [2:0]  scnt_done;

  // Cycle c = period after the c-th posedge; start pulses asserted in the listed cycles
  task automatic run(input int ncyc);
    n_done = 0; done_cyc = -1; done_cyc2 = -1; en_first = -1; en_last = -1;
    busy_c1 = 1'b0; sdone_seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      foreach (starts[i]) if (starts[i] == c) start = 1'b1;
      if (c == 1) busy_c1 = busy;
      if (ro_enable) begin
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c; else done_cyc2 = c;
        cnt_done = count; ovf_done = overflow; busy_done = busy;
        scnt_done = s_count; sovf_done = s_overflow; sdone_seen = s_done;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    mode = 3; rst_n = 1'b0; start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (ro_enable !== 1'b0) begin errors++; $display("FAIL reset_ro_enable got=%b exp=0", ro_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    start = 1'b0; rst_n = 1'b1; mode = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    mode = 0; starts = '{0};
    run(90 + D);
    checks++; if (en_first !== 1) begin errors++; $display("FAIL basic_en_first got=%0d exp=1", en_first); end
    checks++; if (en_last !== 64 + D) begin errors++; $display("FAIL basic_en_last got=%0d exp=%0d", en_last, 64 + D); end
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got=%b exp=1", busy_c1); end
    checks++; if (n_done !== 1 || done_cyc !== 67 + D) begin
      errors++; $display("FAIL basic_done n=%0d cyc=%0d exp n=1 cyc=%0d", n_done, done_cyc, 67 + D); end
    checks++; if (busy_done !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=1", busy_done); end
    checks++; if (cnt_done !== 16'd16) begin errors++; $display("FAIL basic_count got=%0d exp=16", cnt_done); end
    checks++; if (ovf_done !== 1'b0) begin errors++; $display("FAIL basic_overflow got=%b exp=0", ovf_done); end
    checks++; if (busy !== 1'b0 || count !== 16'd16) begin
      errors++; $display("FAIL basic_hold busy=%b count=%0d exp busy=0 count=16", busy, count); end
  endtask

  task automatic test_saturation();
    checks++; if (sdone_seen !== 1'b1 || scnt_done !== 3'd7) begin
      errors++; $display("FAIL sat_count done=%b got=%0d exp=7", sdone_seen, scnt_done); end
    checks++; if (sovf_done !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b exp=1", sovf_done); end
  endtask

  task automatic test_idle_ro();
    mode = 1; repeat (4) @(posedge clk);
    starts = '{0};
    run(90 + D);
    checks++; if (done_cyc !== 67 + D || cnt_done !== 16'd0) begin
      errors++; $display("FAIL idle0 cyc=%0d count=%0d exp cyc=%0d count=0", done_cyc, cnt_done, 67 + D); end
    mode = 2; repeat (4) @(posedge clk);
    run(90 + D);
    checks++; if (n_done !== 1 || cnt_done !== 16'd0) begin
      errors++; $display("FAIL idle1 n=%0d count=%0d exp n=1 count=0", n_done, cnt_done); end
    mode = 0; repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    mode = 0; starts = '{0, 10, 67 + D, 68 + D};
    run(160 + 2 * D);
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_ndone got=%0d exp=2", n_done); end
    checks++; if (done_cyc !== 67 + D) begin errors++; $display("FAIL b2b_done1 got=%0d exp=%0d", done_cyc, 67 + D); end
    checks++; if (done_cyc2 !== 135 + 2 * D) begin
      errors++; $display("FAIL b2b_done2 got=%0d exp=%0d", done_cyc2, 135 + 2 * D); end
    checks++; if (cnt_done !== 16'd16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", cnt_done); end
  endtask

  task automatic test_async_reset();
    mode = 0; starts = '{0};
    run(31);
    checks++; if (ro_enable !== 1'b1) begin errors++; $display("FAIL arst_pre_en got=%b exp=1", ro_enable); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ro_enable !== 1'b0) begin errors++; $display("FAIL arst_ro_enable got=%b exp=0", ro_enable); end
    checks++; if (count !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL arst_state count=%0d busy=%b exp count=0 busy=0", count, busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    starts = '{};
    run(100);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL arst_no_done got=%0d exp=0", n_done); end
    starts = '{0};
    run(90 + D);
    checks++; if (n_done !== 1 || cnt_done !== 16'd16) begin
      errors++; $display("FAIL arst_restart n=%0d count=%0d exp n=1 count=16", n_done, cnt_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_idle_ro();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
